// File: rtl/edge_count_sequencer.sv
// Edge-counting measurement sequencer: counts rising/falling edges of sig_in over a
// programmable window, then presents the saturating counts with a valid/ready handshake.
module edge_count_sequencer #(
   parameter int CNT_W = 8,
   parameter int WIN_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sig_in,
   input  logic             start,
   input  logic [WIN_W-1:0] window_len,
   input  logic             abort,
   input  logic             result_ready,
   output logic             busy,
   output logic             result_valid,
   output logic [CNT_W-1:0] pos_edge,
   output logic [CNT_W-1:0] neg_edge,
   output logic             overflow
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEASURE,
      S_REPORT
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           r_state;
   state_t           w_next_state;
   logic [WIN_W-1:0] r_win_cnt;
   logic             r_sig_d;
   logic [CNT_W-1:0] r_pos;
   logic [CNT_W-1:0] r_neg;
   logic             r_ovf;

   logic w_accept;
   logic w_measure;
   logic w_win_last;
   logic w_rise;
   logic w_fall;

   // A zero-length window is treated as no request at all.
   assign w_accept   = (r_state == S_IDLE) && start && (window_len != '0);
   assign w_measure  = (r_state == S_MEASURE);
   assign w_win_last = (r_win_cnt == WIN_W'(1));
   assign w_rise     =  sig_in && !r_sig_d;
   assign w_fall     = !sig_in &&  r_sig_d;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next_state = S_MEASURE;
         end
         S_MEASURE: begin
            if (abort)           w_next_state = S_IDLE;
            else if (w_win_last) w_next_state = S_REPORT;
         end
         S_REPORT: begin
            if (abort || result_ready) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_win_cnt <= '0;
         r_sig_d   <= 1'b0;
         r_pos     <= '0;
         r_neg     <= '0;
         r_ovf     <= 1'b0;
      end else if (w_accept) begin
         // sig_d is primed here so the acceptance cycle itself never counts an edge.
         r_win_cnt <= window_len;
         r_sig_d   <= sig_in;
         r_pos     <= '0;
         r_neg     <= '0;
         r_ovf     <= 1'b0;
      end else if (w_measure) begin
         r_win_cnt <= r_win_cnt - WIN_W'(1);
         r_sig_d   <= sig_in;
         if (w_rise) begin
            if (r_pos == CNT_MAX) r_ovf <= 1'b1;
            else                  r_pos <= r_pos + CNT_W'(1);
         end
         if (w_fall) begin
            if (r_neg == CNT_MAX) r_ovf <= 1'b1;
            else                  r_neg <= r_neg + CNT_W'(1);
         end
      end
   end

   assign busy         = (r_state != S_IDLE);
   assign result_valid = (r_state == S_REPORT);
   assign pos_edge     = r_pos;
   assign neg_edge     = r_neg;
   assign overflow     = r_ovf;

endmodule
